// File: rtl/arbitro_serial.sv
// Round-robin arbiter that shares one serial transmitter between two byte requesters.
// Moore FSM: inicial -> decide -> partida -> espera -> confirma -> inicial.
module arbitro_serial #(
    parameter int LARGURA        = 8,
    parameter int TIMEOUT_CICLOS = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_a,
    input  logic [LARGURA-1:0] dado_a,
    input  logic               req_b,
    input  logic [LARGURA-1:0] dado_b,
    input  logic               pronto,
    output logic               partida_serial,
    output logic [LARGURA-1:0] dado_serial,
    output logic               ack_a,
    output logic               ack_b,
    output logic               ocupado,
    output logic               erro_timeout,
    output logic [3:0]         db_estado
);

    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'b0000,
        DECIDE   = 4'b0001,
        PARTIDA  = 4'b0010,
        ESPERA   = 4'b0011,
        CONFIRMA = 4'b0100
    } estado_t;

    estado_t         estado_reg;
    logic [CW-1:0]   contador_reg;
    logic            ultimo_b_reg;     // 1: B was served last, so A wins the next tie
    logic            concessao_b_reg;  // requester holding the current grant

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg      <= INICIAL;
            contador_reg    <= '0;
            ultimo_b_reg    <= 1'b1;
            concessao_b_reg <= 1'b0;
            partida_serial  <= 1'b0;
            dado_serial     <= '0;
            ack_a           <= 1'b0;
            ack_b           <= 1'b0;
            erro_timeout    <= 1'b0;
        end else begin
            partida_serial <= 1'b0;
            ack_a          <= 1'b0;
            ack_b          <= 1'b0;
            case (estado_reg)
                INICIAL: begin
                    if (req_a || req_b)
                        estado_reg <= DECIDE;
                end
                DECIDE: begin
                    if (req_a && (!req_b || ultimo_b_reg)) begin
                        concessao_b_reg <= 1'b0;
                        dado_serial     <= dado_a;
                        partida_serial  <= 1'b1;
                        estado_reg      <= PARTIDA;
                    end else if (req_b) begin
                        concessao_b_reg <= 1'b1;
                        dado_serial     <= dado_b;
                        partida_serial  <= 1'b1;
                        estado_reg      <= PARTIDA;
                    end else begin
                        estado_reg <= INICIAL;
                    end
                end
                PARTIDA: begin
                    contador_reg <= '0;
                    estado_reg   <= ESPERA;
                end
                ESPERA: begin
                    // A missing pronto still completes the handshake so the requester is released.
                    if (pronto || contador_reg == CONT_MAX) begin
                        if (!pronto)
                            erro_timeout <= 1'b1;
                        ack_a      <= ~concessao_b_reg;
                        ack_b      <= concessao_b_reg;
                        estado_reg <= CONFIRMA;
                    end else begin
                        contador_reg <= contador_reg + 1'b1;
                    end
                end
                CONFIRMA: begin
                    ultimo_b_reg <= concessao_b_reg;
                    estado_reg   <= INICIAL;
                end
                default: begin
                    estado_reg <= INICIAL;
                end
            endcase
        end
    end

    always_comb begin
        db_estado = 4'b1110;
        ocupado   = 1'b1;
        case (estado_reg)
            INICIAL: begin
                db_estado = 4'b0000;
                ocupado   = 1'b0;
            end
            DECIDE:   db_estado = 4'b0001;
            PARTIDA:  db_estado = 4'b0010;
            ESPERA:   db_estado = 4'b0011;
            CONFIRMA: db_estado = 4'b0100;
            default:  db_estado = 4'b1110;
        endcase
    end

endmodule

// File: tb/tb_arbitro_serial.sv
// Bench for arbitro_serial: timeline model of each transfer checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_arbitro_serial;
    localparam int W   = 8;
    localparam int TMO = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req_a = 1'b0, req_b = 1'b0, pronto = 1'b0;
    logic [W-1:0] dado_a = '0, dado_b = '0;
    logic         partida_serial, ack_a, ack_b, ocupado, erro_timeout;
    logic [W-1:0] dado_serial;
    logic [3:0]   db_estado;

    arbitro_serial #(.LARGURA(W), .TIMEOUT_CICLOS(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .dado_a(dado_a), .req_b(req_b), .dado_b(dado_b),
        .pronto(pronto), .partida_serial(partida_serial), .dado_serial(dado_serial),
        .ack_a(ack_a), .ack_b(ack_b), .ocupado(ocupado),
        .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0, total_cnt = 0;
    int n = 0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total_cnt++;
        if (atual === esperado) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, n);
    endtask

    // Event log filled by the monitor
    logic [W-1:0] sent[$];
    int part_cyc[$];
    int acka_cnt = 0, ackb_cnt = 0, last_ack_cyc = 0, last_pronto_cyc = 0, req_rise_cyc = 0;
    bit prev_req_a = 1'b0;

    // Transfer timeline model: t0 = decide cycle, partida at t0+1, waiting from t0+2,
    // ack in cycle t_end (one after pronto, or after TMO waiting cycles).
    bit           busy = 1'b0, grant_b = 1'b0, last_b = 1'b1, exp_err = 1'b0;
    int           t0 = 0, t_end = -1;
    logic [W-1:0] exp_dado = '0;

    always @(negedge clock) begin
        logic [3:0] e_db;
        bit e_part, e_aa, e_ab;
        n++;
        if (!reset) begin
            busy = 1'b0; last_b = 1'b1; exp_dado = '0; exp_err = 1'b0;
        end
        e_db = 4'd0; e_part = 1'b0; e_aa = 1'b0; e_ab = 1'b0;
        if (busy) begin
            e_db   = (n == t0) ? 4'd1 : (n == t0 + 1) ? 4'd2 : (n == t_end) ? 4'd4 : 4'd3;
            e_part = (n == t0 + 1);
            e_aa   = (n == t_end) && !grant_b;
            e_ab   = (n == t_end) && grant_b;
        end
        chk("modelo_db_estado", 32'(db_estado), 32'(e_db));
        chk("modelo_ocupado", 32'(ocupado), 32'(busy));
        chk("modelo_partida", 32'(partida_serial), 32'(e_part));
        chk("modelo_ack_a", 32'(ack_a), 32'(e_aa));
        chk("modelo_ack_b", 32'(ack_b), 32'(e_ab));
        chk("modelo_dado_serial", 32'(dado_serial), 32'(exp_dado));
        chk("modelo_erro", 32'(erro_timeout), 32'(exp_err));

        if (partida_serial) begin sent.push_back(dado_serial); part_cyc.push_back(n); end
        if (ack_a) begin acka_cnt++; last_ack_cyc = n; end
        if (ack_b) begin ackb_cnt++; last_ack_cyc = n; end
        if (pronto) last_pronto_cyc = n;
        if (req_a && !prev_req_a) req_rise_cyc = n;
        prev_req_a = req_a;

        if (reset) begin
            if (!busy) begin
                if (req_a || req_b) begin busy = 1'b1; t0 = n + 1; t_end = -1; end
            end else if (n == t0) begin
                if (!req_a && !req_b) busy = 1'b0;
                else begin
                    grant_b  = (req_a && req_b) ? !last_b : req_b;
                    exp_dado = grant_b ? dado_b : dado_a;
                end
            end else if (n == t_end) begin
                last_b = grant_b; busy = 1'b0;
            end else if (n >= t0 + 2 && t_end < 0) begin
                if (pronto) t_end = n + 1;
                else if (n - (t0 + 2) == TMO - 1) begin t_end = n + 1; exp_err = 1'b1; end
            end
        end
    end

    // Requesters and transmitter behaviour
    logic [W-1:0] qa[$], qb[$];
    int pronto_delay = 5, pronto_cnt = 0;

    task automatic push_a(input logic [W-1:0] v);
        if (qa.size() == 0) dado_a = v;
        qa.push_back(v); req_a = 1'b1;
    endtask
    task automatic push_b(input logic [W-1:0] v);
        if (qb.size() == 0) dado_b = v;
        qb.push_back(v); req_b = 1'b1;
    endtask

    task automatic tick;
        bit aa, ab, ps;
        @(negedge clock); aa = ack_a; ab = ack_b; ps = partida_serial;
        @(posedge clock); #1;
        if (aa && qa.size() > 0) begin void'(qa.pop_front()); if (qa.size() > 0) dado_a = qa[0]; end
        if (ab && qb.size() > 0) begin void'(qb.pop_front()); if (qb.size() > 0) dado_b = qb[0]; end
        req_a = (qa.size() > 0);
        req_b = (qb.size() > 0);
        pronto = 1'b0;
        if (ps && pronto_delay > 0) pronto_cnt = pronto_delay;
        if (pronto_cnt > 0) begin pronto_cnt--; if (pronto_cnt == 0) pronto = 1'b1; end
    endtask

    task automatic drain(input int limite);
        int c = 0;
        while ((qa.size() > 0 || qb.size() > 0 || ocupado) && c < limite) begin tick; c++; end
        if (c >= limite) begin
            total_cnt++;
            $display("FAIL drain: still busy after %0d cycles", limite);
        end
        tick; tick;
    endtask

    task automatic clear_log;
        sent.delete(); part_cyc.delete(); acka_cnt = 0; ackb_cnt = 0;
    endtask

    task automatic wait_espera;
        int c = 0;
        while (db_estado != 4'd3 && c < 30) begin tick; c++; end
        chk("reach_espera", 32'(c < 30), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acka_before;
        repeat (3) tick;
        chk("reset_db_estado", 32'(db_estado), 32'd0);
        chk("reset_dado_serial", 32'(dado_serial), 32'd0);
        reset = 1'b1;
        tick;

        // Single A request, pronto 5 cycles after partida
        clear_log; pronto_delay = 5;
        push_a(8'h41);
        drain(60);
        chk("s1_sent_count", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("s1_byte", 32'(sent[0]), 32'h41);
        if (part_cyc.size() > 0) begin
            chk("s1_req_to_partida", part_cyc[0] - req_rise_cyc, 32'd2);
            chk("s1_partida_to_pronto", last_pronto_cyc - part_cyc[0], 32'd5);
        end
        chk("s1_pronto_to_ack", last_ack_cyc - last_pronto_cyc, 32'd1);
        chk("s1_ack_a", acka_cnt, 32'd1);
        chk("s1_ack_b", ackb_cnt, 32'd0);

        // Tie after reset: A first, then B, then A again
        reset = 1'b0; tick; tick; reset = 1'b1; tick;
        clear_log; pronto_delay = 3;
        push_a(8'h41); push_b(8'h42);
        drain(100);
        push_a(8'h41); push_b(8'h42);
        drain(100);
        chk("s2_sent_count", 32'(sent.size()), 32'd4);
        if (sent.size() == 4) begin
            chk("s2_order0", 32'(sent[0]), 32'h41);
            chk("s2_order1", 32'(sent[1]), 32'h42);
            chk("s2_order2", 32'(sent[2]), 32'h41);
            chk("s2_order3", 32'(sent[3]), 32'h42);
        end

        // B alone, three bytes back-to-back
        clear_log; pronto_delay = 2;
        push_b(8'h10); push_b(8'h11); push_b(8'h12);
        drain(100);
        chk("s3_ack_b", ackb_cnt, 32'd3);
        chk("s3_ack_a", acka_cnt, 32'd0);
        if (sent.size() == 3) begin
            chk("s3_byte0", 32'(sent[0]), 32'h10);
            chk("s3_byte1", 32'(sent[1]), 32'h11);
            chk("s3_byte2", 32'(sent[2]), 32'h12);
        end else chk("s3_sent_count", 32'(sent.size()), 32'd3);

        // Timeout: no pronto, ack after 16 waiting cycles, flag sticky
        clear_log; pronto_delay = 0;
        push_a(8'h61);
        drain(100);
        chk("s4_erro", 32'(erro_timeout), 32'd1);
        if (part_cyc.size() > 0) chk("s4_partida_to_ack", last_ack_cyc - part_cyc[0], 32'd17);
        chk("s4_ack_a", acka_cnt, 32'd1);
        pronto_delay = 2;
        push_a(8'h62); push_b(8'h63);
        drain(100);
        chk("s4_erro_sticky", 32'(erro_timeout), 32'd1);
        chk("s4_acks_total", acka_cnt + ackb_cnt, 32'd3);

        // Reset during espera abandons the transfer
        clear_log; pronto_delay = 0;
        push_a(8'h71);
        wait_espera;
        tick; tick;
        reset = 1'b0; qa.delete(); req_a = 1'b0; pronto_cnt = 0;
        #1;
        chk("s5_db_estado", 32'(db_estado), 32'd0);
        chk("s5_ocupado", 32'(ocupado), 32'd0);
        chk("s5_dado_serial", 32'(dado_serial), 32'd0);
        chk("s5_erro_cleared", 32'(erro_timeout), 32'd0);
        tick; tick;
        reset = 1'b1;
        tick;
        acka_before = acka_cnt;
        pronto = 1'b1;
        tick; tick; tick; tick;
        chk("s5_no_ack", acka_cnt, acka_before);
        chk("s5_idle", 32'(db_estado), 32'd0);

        // Stray pronto in inicial, then dado_a changes while waiting
        pronto = 1'b1;
        tick;
        chk("s6_pronto_ignored", 32'(db_estado), 32'd0);
        clear_log; pronto_delay = 6;
        push_a(8'h41);
        wait_espera;
        dado_a = 8'h55;
        tick;
        chk("s6_dado_held", 32'(dado_serial), 32'h41);
        drain(60);
        chk("s6_dado_after", 32'(dado_serial), 32'h41);
        chk("s6_ack_a", acka_cnt, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/arbitro_serial.md
ARBITRO_SERIAL -- requirements
Module: arbitro_serial

Interface
REQ-001 SHALL have parameter LARGURA, default 8, width of the data byte on both requesters and on the transmitter.
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 100000, the maximum number of cycles to wait for pronto after a start.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_a  in  1  requester A (pixel frame stream) wants one byte sent; level, held until ack_a.
REQ-006 dado_a  in  LARGURA  byte from requester A.
REQ-007 req_b  in  1  requester B (status/debug messages); same rules as req_a.
REQ-008 dado_b  in  LARGURA  byte from requester B.
REQ-009 pronto  in  1  one-cycle pulse from the serial transmitter: byte finished.
REQ-010 partida_serial  out  1  one-cycle start pulse to the serial transmitter.
REQ-011 dado_serial  out  LARGURA  registered byte presented to the transmitter.
REQ-012 ack_a / ack_b  out  1 each  one-cycle pulse: the granted byte is done.
REQ-013 ocupado  out  1  high in every state except inicial.
REQ-014 erro_timeout  out  1  sticky flag: a transmission timed out.
REQ-015 db_estado  out  4  current state code for debug.

Function
REQ-016 SHALL be a Moore FSM with states inicial=0000, decide=0001, partida=0010, espera=0011, confirma=0100; any other code SHALL show db_estado=1110 and go to inicial.
REQ-017 inicial: if req_a or req_b is high, go to decide; else stay.
REQ-018 decide: choose the grant, latch the granted byte into dado_serial, and go to partida.
REQ-019 Grant rules: if only one request is high, grant it; if both are high, grant the requester not served last (round-robin); if neither is high, grant nothing and return to inicial.
REQ-020 The last-served register SHALL update only in confirma.
REQ-021 partida: partida_serial=1 for exactly this cycle; go to espera.
REQ-022 espera: pronto=1 goes to confirma. A free-running counter, cleared on entry, SHALL reach TIMEOUT_CICLOS-1 without pronto and then set erro_timeout and go to confirma.
REQ-023 confirma: pulse ack of the granted requester for this cycle only; go to inicial.
REQ-024 Latency with an idle arbiter: req sampled high at edge N gives partida_serial high in cycle N+2; pronto sampled at edge M gives ack high in cycle M+1.
REQ-025 A requester SHALL deassert req on the edge that samples its ack; the arbiter does not filter a req still high in inicial.
REQ-026 pronto outside espera SHALL be ignored.
REQ-027 dado_a/dado_b changes after decide SHALL NOT affect dado_serial.
REQ-028 A req dropped after grant SHALL NOT abort the transfer; ack is still pulsed.
REQ-029 Exactly one of ack_a/ack_b is high at a time; never both.
REQ-030 erro_timeout SHALL stay high until reset.

Reset
REQ-031 While reset=0: state inicial, db_estado=0000, partida_serial=0, ack_a=ack_b=0, ocupado=0, dado_serial=0, erro_timeout=0, counter=0, last-served=B (A wins the first tie).
REQ-032 Reset mid-operation SHALL abandon the transfer immediately with no ack; outputs take reset values asynchronously.

Verification
REQ-033 Only req_a, dado_a=0x41, pronto 5 cycles after partida -> one partida pulse 2 cycles after req, dado_serial=0x41, ack_a pulse 1 cycle after pronto, ack_b never high.
REQ-034 req_a (0x41) and req_b (0x42) both high after reset -> 0x41 sent then 0x42, in that order; both re-requested -> 0x41 next.
REQ-035 req_b alone, 3 bytes 0x10/0x11/0x12 -> served back-to-back, three ack_b pulses, no ack_a.
REQ-036 TIMEOUT_CICLOS=16, no pronto -> ack_a after 16 espera cycles, erro_timeout=1 and still 1 after two more transfers.
REQ-037 reset=0 during espera -> db_estado=0000 and all outputs 0 at once; a later pronto gives no ack.
REQ-038 pronto pulsed in inicial, and dado_a changed 0x41->0x55 in espera -> no state change, dado_serial stays 0x41.
